// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 pipeline controller:
// opcodes, MRET word, PC select, controller states and trap causes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] MRET_WORD = 32'h30200073;

  typedef enum logic [1:0] {
    PC_NEXT  = 2'b00,
    PC_ALU   = 2'b01,
    PC_MTVEC = 2'b10,
    PC_MEPC  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

  localparam logic [3:0] CAUSE_EXT_IRQ     = 4'd11;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

endpackage

// File: rtl/rv_operand_usage.sv
// Classifies one RV32 instruction word by the register
// operands it reads/writes and whether it touches data memory.
module rv_operand_usage
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_mem,
  output logic        is_load
);

  logic [6:0] op;
  logic [2:0] f3;
  logic       csr;
  logic       unused_bits;

  assign op  = instr[6:0];
  assign f3  = instr[14:12];
  assign csr = (op == OP_SYSTEM) && (f3 != 3'd0);

  assign writes_rd = (op inside {OP_OP, OP_IMM, OP_LOAD,
                      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
                     || csr;
  // CSR immediate forms (funct3[2]=1) carry uimm in rs1
  assign uses_rs1  = (op inside {OP_OP, OP_IMM, OP_LOAD,
                      OP_STORE, OP_BRANCH, OP_JALR})
                     || (csr && !f3[2]);
  assign uses_rs2  = op inside {OP_OP, OP_STORE, OP_BRANCH};
  assign is_load   = (op == OP_LOAD);
  assign is_mem    = is_load || (op == OP_STORE);

  assign unused_bits = ^{instr[31:15], instr[11:7]};

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush/forward/PC-select sequencer for the 3-stage
// RV32 pipeline, with memory wait-state and trap handling.
module pipeline_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] de_instr,
  input  logic        de_valid,
  input  logic [31:0] wb_instr,
  input  logic        wb_valid,
  input  logic        br_taken,
  input  logic        dmem_ready,
  input  logic        irq,
  input  logic        mie,
  output logic        stall_if,
  output logic        stall_de,
  output logic        flush_de,
  output logic [1:0]  pc_sel,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        trap_taken,
  output logic        epc_sel,
  output logic        trap_irq,
  output logic [3:0]  trap_cause
);

  logic de_rs1, de_rs2, de_wr, de_mem, de_load;
  logic wb_rs1, wb_rs2, wb_wr, wb_mem, wb_load;
  logic unused_ok;

  rv_operand_usage u_de (
    .instr     (de_instr),
    .uses_rs1  (de_rs1),
    .uses_rs2  (de_rs2),
    .writes_rd (de_wr),
    .is_mem    (de_mem),
    .is_load   (de_load)
  );

  rv_operand_usage u_wb (
    .instr     (wb_instr),
    .uses_rs1  (wb_rs1),
    .uses_rs2  (wb_rs2),
    .writes_rd (wb_wr),
    .is_mem    (wb_mem),
    .is_load   (wb_load)
  );

  assign unused_ok = ^{de_wr, de_mem, de_load, wb_rs1, wb_rs2};

  ctrl_state_e state, state_n;
  logic [9:0]  wait_cnt, wait_n;
  logic [1:0]  flush_cnt, flush_n;

  logic    wb_hit, jump, is_mret, redirect;
  logic    mem_pend, irq_take, go_flush;
  logic    s_if, s_de, fl, tr, epc, ti;
  logic [3:0] cause;
  pc_sel_e pc;

  assign wb_hit = wb_valid && wb_wr
                  && (wb_instr[11:7] != 5'd0);
  assign fwd_a  = !rst && wb_hit && de_rs1
                  && (wb_instr[11:7] == de_instr[19:15]);
  assign fwd_b  = !rst && wb_hit && de_rs2
                  && (wb_instr[11:7] == de_instr[24:20]);

  assign jump = de_valid
    && ((de_instr[6:0] == OP_JAL)
     || (de_instr[6:0] == OP_JALR)
     || ((de_instr[6:0] == OP_BRANCH) && br_taken));
  assign is_mret  = de_valid && (de_instr == MRET_WORD);
  assign redirect = jump || is_mret;
  assign mem_pend = wb_valid && wb_mem && !dmem_ready;
  assign irq_take = irq && mie && de_valid;

  always_comb begin
    state_n  = state;
    wait_n   = wait_cnt;
    flush_n  = flush_cnt;
    go_flush = 1'b0;
    s_if     = 1'b0;
    s_de     = 1'b0;
    fl       = 1'b0;
    tr       = 1'b0;
    epc      = 1'b0;
    ti       = 1'b0;
    cause    = 4'd0;
    pc       = PC_NEXT;
    unique case (state)
      RUN: begin
        if (mem_pend) begin
          s_if    = 1'b1;
          s_de    = 1'b1;
          state_n = MEM_WAIT;
          wait_n  = 10'd1;
        end else if (irq_take) begin
          // DE is replayed after the handler, so its redirect is dropped
          tr       = 1'b1;
          ti       = 1'b1;
          cause    = CAUSE_EXT_IRQ;
          pc       = PC_MTVEC;
          go_flush = 1'b1;
        end else if (redirect) begin
          pc       = is_mret ? PC_MEPC : PC_ALU;
          go_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_n = RUN;
          wait_n  = '0;
          if (redirect) begin
            pc       = is_mret ? PC_MEPC : PC_ALU;
            go_flush = 1'b1;
          end
        end else if (wait_cnt == 10'(MEM_TIMEOUT)) begin
          tr       = 1'b1;
          epc      = 1'b1;
          cause    = wb_load ? CAUSE_LOAD_FAULT
                             : CAUSE_STORE_FAULT;
          pc       = PC_MTVEC;
          go_flush = 1'b1;
          wait_n   = '0;
        end else begin
          s_if   = 1'b1;
          s_de   = 1'b1;
          wait_n = wait_cnt + 10'd1;
        end
      end
      FLUSH: begin
        fl      = (flush_cnt != 2'd0);
        flush_n = flush_cnt - 2'd1;
        if (flush_cnt <= 2'd1) begin
          state_n = RUN;
          flush_n = '0;
        end
      end
      default: state_n = RUN;
    endcase
    if (go_flush) begin
      fl = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        flush_n = 2'(FLUSH_CYCLES - 1);
      end else begin
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      flush_cnt <= flush_n;
    end
  end

  // Reset forces every output low even while inputs are live
  assign stall_if   = !rst && s_if;
  assign stall_de   = !rst && s_de;
  assign flush_de   = !rst && fl;
  assign pc_sel     = rst ? 2'b00 : pc;
  assign trap_taken = !rst && tr;
  assign epc_sel    = !rst && epc;
  assign trap_irq   = !rst && ti;
  assign trap_cause = rst ? 4'd0 : cause;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed vector table plus hand sequences for the
// pipeline controller (wait states, timeout, flush, irq, reset).
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] de_instr, wb_instr;
  logic        de_valid, wb_valid, br_taken;
  logic        dmem_ready, irq, mie;

  logic        stall_if, stall_de, flush_de;
  logic [1:0]  pc_sel;
  logic        fwd_a, fwd_b, trap_taken;
  logic        epc_sel, trap_irq;
  logic [3:0]  trap_cause;

  logic        s1_if, s1_de, f1_de;
  logic [1:0]  pc1;
  logic        fa1, fb1, t1, e1, ti1;
  logic [3:0]  c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_controller #(
    .MEM_TIMEOUT  (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .de_instr   (de_instr),
    .de_valid   (de_valid),
    .wb_instr   (wb_instr),
    .wb_valid   (wb_valid),
    .br_taken   (br_taken),
    .dmem_ready (dmem_ready),
    .irq        (irq),
    .mie        (mie),
    .stall_if   (stall_if),
    .stall_de   (stall_de),
    .flush_de   (flush_de),
    .pc_sel     (pc_sel),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .trap_taken (trap_taken),
    .epc_sel    (epc_sel),
    .trap_irq   (trap_irq),
    .trap_cause (trap_cause)
  );

  pipeline_controller #(
    .MEM_TIMEOUT  (6),
    .FLUSH_CYCLES (1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .de_instr   (de_instr),
    .de_valid   (de_valid),
    .wb_instr   (wb_instr),
    .wb_valid   (wb_valid),
    .br_taken   (br_taken),
    .dmem_ready (dmem_ready),
    .irq        (irq),
    .mie        (mie),
    .stall_if   (s1_if),
    .stall_de   (s1_de),
    .flush_de   (f1_de),
    .pc_sel     (pc1),
    .fwd_a      (fa1),
    .fwd_b      (fb1),
    .trap_taken (t1),
    .epc_sel    (e1),
    .trap_irq   (ti1),
    .trap_cause (c1)
  );

  logic [13:0] obs;
  assign obs = {stall_if, stall_de, flush_de, pc_sel,
                fwd_a, fwd_b, trap_taken, epc_sel,
                trap_irq, trap_cause};

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_X5  = 32'h00208293;
  localparam logic [31:0] ADD_655 = 32'h00528333;
  localparam logic [31:0] ADDI_X7 = 32'h00528393;
  localparam logic [31:0] SW_WB   = 32'h0020A2A3;
  localparam logic [31:0] SW_DE   = 32'h0050A023;
  localparam logic [31:0] CSRRW   = 32'h300290F3;
  localparam logic [31:0] CSRRWI  = 32'h3002D0F3;
  localparam logic [31:0] LUI_X6  = 32'h00528337;
  localparam logic [31:0] BEQ_55  = 32'h00528063;
  localparam logic [31:0] BEQ_12  = 32'h00208063;
  localparam logic [31:0] JAL_X1  = 32'h000000EF;
  localparam logic [31:0] JALR_X0 = 32'h00008067;
  localparam logic [31:0] MRET    = 32'h30200073;

  typedef struct {
    string       name;
    logic [31:0] de_i;
    logic        dv;
    logic [31:0] wb_i;
    logic        wv, bt, rdy, ir, me;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [13:0] mk(
    input logic [1:0] st, input logic fl,
    input logic [1:0] pc, input logic fa,
    input logic fb, input logic tr,
    input logic ep, input logic ti,
    input logic [3:0] c);
    return {st, fl, pc, fa, fb, tr, ep, ti, c};
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] di,
                       input logic dv,
                       input logic [31:0] wi,
                       input logic wv, input logic bt,
                       input logic rdy, input logic ir,
                       input logic me);
    de_instr   = di;
    de_valid   = dv;
    wb_instr   = wi;
    wb_valid   = wv;
    br_taken   = bt;
    dmem_ready = rdy;
    irq        = ir;
    mie        = me;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tmo(input logic [31:0] wi,
                     input logic [3:0] cause,
                     input string nm);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(32'h0, 1'b0, wi, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (i < 4)
        chk({nm, "_wait"}, obs, mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
      else
        chk({nm, "_trap"}, obs,
            mk(2'b00, 1, 2'b10, 0, 0, 1, 1, 0, cause));
    end
    @(negedge clk);
    idle();
    #1;
    chk({nm, "_flush"}, obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    chk({nm, "_run"}, obs, 14'h0);
  endtask

  initial begin
    vecs[0]  = '{"fwd_lw", ADD_655, 1, LW_X5, 1, 0, 1, 0, 0,
                 mk(0, 0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[1]  = '{"fwd_x0", ADD_655, 1, LW_X0, 1, 0, 1, 0, 0,
                 14'h0};
    vecs[2]  = '{"fwd_addi", ADDI_X7, 1, ADD_X5, 1, 0, 1, 0, 0,
                 mk(0, 0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[3]  = '{"fwd_wb_st", ADD_655, 1, SW_WB, 1, 0, 1, 0, 0,
                 14'h0};
    vecs[4]  = '{"fwd_de_st", SW_DE, 1, ADD_X5, 1, 0, 1, 0, 0,
                 mk(0, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[5]  = '{"fwd_csr", CSRRW, 1, ADD_X5, 1, 0, 1, 0, 0,
                 mk(0, 0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[6]  = '{"fwd_csri", CSRRWI, 1, ADD_X5, 1, 0, 1, 0, 0,
                 14'h0};
    vecs[7]  = '{"fwd_wbinv", ADD_655, 1, ADD_X5, 0, 0, 1, 0, 0,
                 14'h0};
    vecs[8]  = '{"fwd_lui", LUI_X6, 1, ADD_X5, 1, 0, 1, 0, 0,
                 14'h0};
    vecs[9]  = '{"fwd_beq", BEQ_55, 1, ADD_X5, 1, 0, 1, 0, 0,
                 mk(0, 0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[10] = '{"beq_tk", BEQ_12, 1, 32'h0, 0, 1, 1, 0, 0,
                 mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{"beq_nt", BEQ_12, 1, 32'h0, 0, 0, 1, 0, 0,
                 14'h0};
    vecs[12] = '{"jal", JAL_X1, 1, 32'h0, 0, 0, 1, 0, 0,
                 mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0)};
    vecs[13] = '{"jalr", JALR_X0, 1, 32'h0, 0, 0, 1, 0, 0,
                 mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0)};
    vecs[14] = '{"mret", MRET, 1, 32'h0, 0, 0, 1, 0, 0,
                 mk(0, 1, 2'b11, 0, 0, 0, 0, 0, 0)};
    vecs[15] = '{"irq_jal", JAL_X1, 1, 32'h0, 0, 0, 1, 1, 1,
                 mk(0, 1, 2'b10, 0, 0, 1, 0, 1, 4'd11)};
    vecs[16] = '{"irq_mie0", JAL_X1, 1, 32'h0, 0, 0, 1, 1, 0,
                 mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0)};
    vecs[17] = '{"irq_nodv", JAL_X1, 0, 32'h0, 0, 0, 1, 1, 1,
                 14'h0};
    vecs[18] = '{"stall_prio", JAL_X1, 1, LW_X5, 1, 0, 0, 1, 1,
                 mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1;
    idle();
    @(negedge clk);
    #1;
    chk("reset_outs", obs, 14'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset", obs, 14'h0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].de_i, vecs[k].dv, vecs[k].wb_i,
            vecs[k].wv, vecs[k].bt, vecs[k].rdy,
            vecs[k].ir, vecs[k].me);
      #1;
      chk(vecs[k].name, obs, vecs[k].exp);
      repeat (2) begin
        @(negedge clk);
        idle();
      end
    end

    // store with three cycles of wait
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(32'h0, 1'b0, SW_WB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("sw_wait", obs, mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("sw_wait1", {s1_if, s1_de}, 2'b11);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    chk("sw_release", obs, 14'h0);
    @(negedge clk);
    idle();

    tmo(LW_X5, 4'd5, "lw_tmo");
    tmo(SW_WB, 4'd7, "sw_tmo");

    // taken branch, then an irq held across the flush cycle
    @(negedge clk);
    drive(BEQ_12, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("br_c0", obs, mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    chk("br_c0_fc1", f1_de, 1'b1);
    @(negedge clk);
    drive(ADD_655, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("br_c1", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("br_c1_fc1_trap", t1, 1'b1);
    @(negedge clk);
    #1;
    chk("br_c2_irq", obs, mk(0, 1, 2'b10, 0, 0, 1, 0, 1, 4'd11));
    @(negedge clk);
    idle();
    #1;
    chk("irq_flush", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    chk("irq_run", obs, 14'h0);

    // reset while waiting on memory
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(32'h0, 1'b0, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rst_pre", obs, mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid", obs, 14'h0);
    chk("rst_mid1", {s1_if, s1_de, t1}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rst_after", obs, 14'h0);
    tmo(LW_X5, 4'd5, "rst_tmo");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
